// File: rtl/dadda_err_monitor.sv
// dadda_err_monitor
// Consumes operand/product triples from an 8-bit Dadda multiplier under test,
// recomputes the exact product, and accumulates error-distance statistics
// (sample count, error count, saturating ED sum, maximum ED with its operands)
// over a programmable window of samples.
//
// Handshake: a triple transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_valid may be raised or dropped freely by the
// producer; in_ready is registered and only depends on the window progress.
module dadda_err_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH:0]     approx_prod,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     sum_ed,
    output logic                 sum_sat,
    output logic [2*WIDTH:0]     max_ed,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b,
    output logic [1:0]           fsm_state
);

    // Product / ED width and a sum width wide enough to hold any ACC value
    // plus any ED without wrapping, so the clamp compare is exact.
    localparam int PW = 2 * WIDTH + 1;
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   win_len;
    logic [CNT_W-1:0]   acc_n;
    logic [CNT_W-1:0]   acc_n_nxt;

    logic               s1_valid;
    logic [PW-1:0]      s1_ed;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic               s2_valid;

    logic [2*WIDTH-1:0] exact;
    logic [PW-1:0]      exact_ext;
    logic [PW-1:0]      ed_in;
    logic               transfer;
    logic               start_take;
    logic [SW-1:0]      sum_wide;
    logic [SW-1:0]      sum_max;
    logic               sum_clamp;

    assign fsm_state = state;

    // Exact product and unsigned error distance, evaluated in full width so
    // an approximate product above the exact one never wraps.
    always_comb begin
        exact      = op_a * op_b;
        exact_ext  = {1'b0, exact};
        ed_in      = '0;
        if (exact_ext >= approx_prod) begin
            ed_in = exact_ext - approx_prod;
        end else begin
            ed_in = approx_prod - exact_ext;
        end
        transfer   = in_valid && in_ready;
        start_take = start && ((state == IDLE) || (state == DONE));
        acc_n_nxt  = acc_n + CNT_W'(1);
        sum_wide   = SW'(sum_ed) + SW'(s1_ed);
        sum_max    = SW'({ACC_W{1'b1}});
        sum_clamp  = (sum_wide > sum_max);
    end

    // Window control FSM with registered in_ready, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            win_len  <= '0;
            acc_n    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        win_len <= num_samples;
                        acc_n   <= '0;
                        if (num_samples == '0) begin
                            // Empty window: statistics are already cleared.
                            state    <= DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= RUN;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately ignored while a window is open.
                    if (transfer) begin
                        acc_n <= acc_n_nxt;
                        if (acc_n_nxt == win_len) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture ED and operands of each transferred triple; stage 2
    // valid tracks the cycle in which the statistics absorb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
        end else if (start_take) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= transfer;
            s2_valid <= s1_valid;
            if (transfer) begin
                s1_ed <= ed_in;
                s1_a  <= op_a;
                s1_b  <= op_b;
            end
        end
    end

    // Stage 2: fold the stage-1 sample into the window statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            sum_sat    <= 1'b0;
            max_ed     <= '0;
            max_a      <= '0;
            max_b      <= '0;
        end else if (start_take) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            sum_sat    <= 1'b0;
            max_ed     <= '0;
            max_a      <= '0;
            max_b      <= '0;
        end else if (s1_valid) begin
            // Counters hold at all-ones rather than wrapping.
            if (sample_cnt != '1) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if ((s1_ed != '0) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (sum_clamp) begin
                sum_ed  <= {ACC_W{1'b1}};
                sum_sat <= 1'b1;
            end else begin
                sum_ed  <= sum_wide[ACC_W-1:0];
            end
            // Strictly greater: on ties the earlier sample's operands stay.
            if (s1_ed > max_ed) begin
                max_ed <= s1_ed;
                max_a  <= s1_a;
                max_b  <= s1_b;
            end
        end
    end

endmodule

// File: tb/tb_dadda_err_monitor.sv
// Directed bench for dadda_err_monitor: table-driven measurement windows plus
// hand-written sequences for reset, handshake, empty window and saturation.
module tb_dadda_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [16:0] approx_prod;
    logic        busy;
    logic        done;
    logic [15:0] sample_cnt;
    logic [15:0] err_cnt;
    logic [31:0] sum_ed;
    logic        sum_sat;
    logic [16:0] max_ed;
    logic [7:0]  max_a;
    logic [7:0]  max_b;
    logic [1:0]  fsm_state;

    // Narrow-accumulator instance sharing the same stimulus.
    logic        in_ready8;
    logic        busy8;
    logic        done8;
    logic [15:0] sample_cnt8;
    logic [15:0] err_cnt8;
    logic [7:0]  sum_ed8;
    logic        sum_sat8;
    logic [16:0] max_ed8;
    logic [7:0]  max_a8;
    logic [7:0]  max_b8;
    logic [1:0]  fsm_state8;

    int n_cmp  = 0;
    int n_fail = 0;

    dadda_err_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .approx_prod(approx_prod), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed),
        .sum_sat(sum_sat), .max_ed(max_ed), .max_a(max_a), .max_b(max_b),
        .fsm_state(fsm_state)
    );

    dadda_err_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready8), .op_a(op_a), .op_b(op_b),
        .approx_prod(approx_prod), .busy(busy8), .done(done8),
        .sample_cnt(sample_cnt8), .err_cnt(err_cnt8), .sum_ed(sum_ed8),
        .sum_sat(sum_sat8), .max_ed(max_ed8), .max_a(max_a8), .max_b(max_b8),
        .fsm_state(fsm_state8)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] p;
    } samp_t;

    typedef struct {
        int          n;
        int          first;
        logic [15:0] e_samples;
        logic [15:0] e_errs;
        logic [31:0] e_sum;
        logic [16:0] e_max;
        logic [7:0]  e_ma;
        logic [7:0]  e_mb;
    } win_t;

    samp_t samps[18];
    win_t  wins[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drivers: every drive happens 1ns after a rising edge.
    task automatic start_win(input logic [15:0] n);
        start       = 1'b1;
        num_samples = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [16:0] p);
        int guard;
        in_valid    = 1'b1;
        op_a        = a;
        op_b        = b;
        approx_prod = p;
        guard       = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
        end
    endtask

    task automatic check_stats(input string tag, input win_t w);
        chk({tag, "_sample_cnt"}, sample_cnt, w.e_samples);
        chk({tag, "_err_cnt"}, err_cnt, w.e_errs);
        chk({tag, "_sum_ed"}, sum_ed, w.e_sum);
        chk({tag, "_max_ed"}, max_ed, w.e_max);
        chk({tag, "_max_a"}, max_a, w.e_ma);
        chk({tag, "_max_b"}, max_b, w.e_mb);
        chk({tag, "_sum_sat"}, sum_sat, 0);
    endtask

    task automatic run_window(input int k);
        int    cyc;
        string tag;
        tag = $sformatf("win%0d", k);
        start_win(16'(wins[k].n));
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < wins[k].n; i++) begin
            send(samps[wins[k].first + i].a, samps[wins[k].first + i].b,
                 samps[wins[k].first + i].p);
        end
        wait_done(cyc);
        chk({tag, "_done_latency"}, cyc, 3);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_fsm_done"}, fsm_state, 3);
        check_stats(tag, wins[k]);
    endtask

    initial begin
        int cyc;
        int xfers;

        // Stimulus tables: samples and per-window expected statistics.
        samps[0]  = '{a: 8'd3,   b: 8'd5,   p: 17'd15};
        samps[1]  = '{a: 8'd255, b: 8'd255, p: 17'd65025};
        samps[2]  = '{a: 8'd0,   b: 8'd77,  p: 17'd0};
        samps[3]  = '{a: 8'd255, b: 8'd255, p: 17'd65024};
        samps[4]  = '{a: 8'd10,  b: 8'd10,  p: 17'd120};
        samps[5]  = '{a: 8'd4,   b: 8'd4,   p: 17'd16};
        samps[6]  = '{a: 8'd7,   b: 8'd9,   p: 17'd70};
        samps[7]  = '{a: 8'd2,   b: 8'd3,   p: 17'd0};
        samps[8]  = '{a: 8'd12,  b: 8'd12,  p: 17'd144};
        samps[9]  = '{a: 8'd5,   b: 8'd5,   p: 17'd30};
        samps[10] = '{a: 8'd6,   b: 8'd6,   p: 17'd41};
        samps[11] = '{a: 8'd1,   b: 8'd1,   p: 17'd1};
        samps[12] = '{a: 8'd200, b: 8'd100, p: 17'd0};
        samps[13] = '{a: 8'd1,   b: 8'd1,   p: 17'd131071};
        for (int i = 14; i < 18; i++) samps[i] = '{a: 8'd0, b: 8'd0, p: 17'd0};

        wins[0] = '{n: 3, first: 0,  e_samples: 3, e_errs: 0, e_sum: 0,      e_max: 0,      e_ma: 0,   e_mb: 0};
        wins[1] = '{n: 3, first: 3,  e_samples: 3, e_errs: 2, e_sum: 21,     e_max: 20,     e_ma: 10,  e_mb: 10};
        wins[2] = '{n: 3, first: 6,  e_samples: 3, e_errs: 2, e_sum: 13,     e_max: 7,      e_ma: 7,   e_mb: 9};
        wins[3] = '{n: 3, first: 9,  e_samples: 3, e_errs: 2, e_sum: 10,     e_max: 5,      e_ma: 5,   e_mb: 5};
        wins[4] = '{n: 1, first: 12, e_samples: 1, e_errs: 1, e_sum: 20000,  e_max: 20000,  e_ma: 200, e_mb: 100};
        wins[5] = '{n: 1, first: 13, e_samples: 1, e_errs: 1, e_sum: 131070, e_max: 131070, e_ma: 1,   e_mb: 1};

        // Reset
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        op_a = '0; op_b = '0; approx_prod = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fsm", fsm_state, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_window(0);
        run_window(1);

        // Asynchronous reset in the middle of a RUN window.
        start_win(3);
        send(8'd10, 8'd10, 17'd120);
        send(8'd4, 8'd4, 17'd17);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sample_cnt", sample_cnt, 0);
        chk("midrst_sum_ed", sum_ed, 0);
        chk("midrst_max_ed", max_ed, 0);
        chk("midrst_fsm", fsm_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 2; k < 6; k++) run_window(k);

        // Empty window: done on the very next edge, statistics zero.
        start_win(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_sample_cnt", sample_cnt, 0);
        chk("zero_sum_ed", sum_ed, 0);
        chk("zero_max_ed", max_ed, 0);
        chk("zero_in_ready", in_ready, 0);

        // Handshake: in_valid 1,0,1,1 with a window of 2, start pulsed in RUN.
        xfers = 0;
        start_win(2);
        in_valid = 1'b1; op_a = 8'd2; op_b = 8'd2; approx_prod = 17'd4;
        @(negedge clk); if (in_valid && in_ready) xfers++;
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b1; num_samples = 16'd9;
        @(negedge clk); if (in_valid && in_ready) xfers++;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; op_a = 8'd3; op_b = 8'd3; approx_prod = 17'd10;
        @(negedge clk); if (in_valid && in_ready) xfers++;
        @(posedge clk); #1;
        op_a = 8'd9; op_b = 8'd9; approx_prod = 17'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hs_ready_low%0d", i), in_ready, 0);
            if (in_valid && in_ready) xfers++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("hs_transfers", xfers, 2);
        wait_done(cyc);
        chk("hs_sample_cnt", sample_cnt, 2);
        chk("hs_err_cnt", err_cnt, 1);
        chk("hs_sum_ed", sum_ed, 1);
        chk("hs_max_ed", max_ed, 1);
        chk("hs_max_a", max_a, 3);
        chk("hs_max_b", max_b, 3);

        // Saturation on the 8-bit accumulator: 200 + 100 clamps to 255.
        start_win(2);
        send(8'd0, 8'd0, 17'd200);
        send(8'd0, 8'd0, 17'd100);
        wait_done(cyc);
        chk("sat8_sum_ed", sum_ed8, 255);
        chk("sat8_sum_sat", sum_sat8, 1);
        chk("sat8_err_cnt", err_cnt8, 2);
        chk("sat32_sum_ed", sum_ed, 300);
        chk("sat32_sum_sat", sum_sat, 0);

        // Reset while DRAIN holds an in-flight sample.
        start_win(1);
        send(8'd10, 8'd10, 17'd120);
        chk("drain_fsm", fsm_state, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("drainrst_fsm", fsm_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("drainrst_done", done, 0);
        chk("drainrst_sample_cnt", sample_cnt, 0);
        chk("drainrst_sum_ed", sum_ed, 0);
        chk("drainrst_fsm_idle", fsm_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
